// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO multiply unit.
//   MULT, MULTU, MADD and MSUB are computed by a 32-step shift-add sequencer
//   (IDLE -> MUL x WIDTH -> FIX). The result commits to {Hi,Lo} at the FIX
//   edge. MTHI and MTLO write Hi or Lo directly in a single cycle.
// Ports:
//   Clk      - clock, rising edge
//   Reset_n  - asynchronous active-low reset
//   Start    - issue Op this cycle (honoured only in IDLE and without Flush)
//   Op[2:0]  - 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO
//   A, B     - rs / rt operands
//   Flush    - abort an in-flight operation, or block a Start in IDLE
//   Busy     - multi-cycle operation in flight
//   Done     - one-cycle pulse after a multi-cycle result commits
//   Hi, Lo   - architectural HI / LO registers
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_neg;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_prod;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_idle;
    logic             w_accept_mul;
    logic             w_accept_mt;
    logic             w_signed;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_last;
    logic [PW-1:0]    w_step;
    logic [PW-1:0]    w_fixed;
    logic [PW-1:0]    w_hilo;
    logic [PW-1:0]    w_result;
    logic             w_commit;

    assign w_idle       = (r_state == S_IDLE);
    assign w_accept_mul = w_idle && Start && !Flush && !Op[2];
    assign w_accept_mt  = w_idle && Start && !Flush && (Op[2:1] == 2'b10);
    assign w_signed     = (Op[1:0] != 2'b01);

    // Signed ops run on magnitudes; the sign is restored in FIX. The most
    // negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_a_abs = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_b_abs = (w_signed && B[WIDTH-1]) ? -B : B;

    assign w_last = (r_cnt == CW'(WIDTH - 1));
    // Step k adds A << k when bit k of the multiplier is set.
    assign w_step = r_prod + (r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0);

    assign w_fixed  = r_neg ? -r_prod : r_prod;
    assign w_hilo   = {r_hi, r_lo};
    assign w_commit = (r_state == S_FIX) && !Flush;

    always_comb begin
        w_result = w_fixed;
        case (r_op)
            2'b10:   w_result = w_hilo + w_fixed;
            2'b11:   w_result = w_hilo - w_fixed;
            default: w_result = w_fixed;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept_mul) w_state_next = S_MUL;
            S_MUL: begin
                if (Flush)       w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_FIX;
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_prod <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            case (r_state)
                S_IDLE: begin
                    if (w_accept_mul) begin
                        r_a    <= w_a_abs;
                        r_b    <= w_b_abs;
                        r_op   <= Op[1:0];
                        r_neg  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_cnt  <= '0;
                        r_prod <= '0;
                    end
                    if (w_accept_mt) begin
                        if (Op[0]) r_lo <= A;
                        else       r_hi <= A;
                    end
                end
                S_MUL: begin
                    if (!Flush) begin
                        r_prod <= w_step;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (w_commit) begin
                        {r_hi, r_lo} <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = !w_idle;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases for the listed
// vectors, flush/ignore/reset behaviour, then randomized ops against a
// 64-bit arithmetic model of the HI/LO pair.
module tb_muldiv_sequencer;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int          n_vec = 0;
    int          n_miscmp = 0;
    logic [63:0] model_hilo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Flush   (Flush),
        .Busy    (Busy),
        .Done    (Done),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Reference: full-precision product, then the HI/LO update rule.
    function automatic logic [63:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 3'd1) p = {32'd0, a} * {32'd0, b};
        else            p = 64'(sa * sb);
        case (op)
            3'd0, 3'd1: return p;
            3'd2:       return hilo + p;
            3'd3:       return hilo - p;
            3'd4:       return {a, hilo[31:0]};
            3'd5:       return {hilo[63:32], a};
            default:    return hilo;
        endcase
    endfunction

    // Issue a multiply-class op and follow it to commit.
    task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        int dones;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        model_hilo = model_op(op, a, b, model_hilo);
        cyc = 0;
        dones = 0;
        while (Busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (Done) dones++;
            @(negedge Clk);
        end
        check_value($sformatf("op%0d busy_cycles", op), 64'(cyc), 64'd33);
        check_value($sformatf("op%0d done_while_busy", op), 64'(dones), 64'd0);
        check_value($sformatf("op%0d done_pulse", op), 64'(Done), 64'd1);
        check_value($sformatf("op%0d a=%h b=%h hilo", op, a, b), {Hi, Lo}, model_hilo);
        @(negedge Clk);
        check_value($sformatf("op%0d done_clear", op), 64'(Done), 64'd0);
    endtask

    // Issue a single-cycle or ignored op.
    task automatic run_single(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        model_hilo = model_op(op, a, b, model_hilo);
        check_value($sformatf("op%0d busy", op), 64'(Busy), 64'd0);
        check_value($sformatf("op%0d done", op), 64'(Done), 64'd0);
        check_value($sformatf("op%0d a=%h hilo", op, a), {Hi, Lo}, model_hilo);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int dones;
        int busys;
        dones = 0;
        busys = 0;
        repeat (n) begin
            @(negedge Clk);
            if (Done) dones++;
            if (Busy) busys++;
        end
        check_value({tag, " done_count"}, 64'(dones), 64'd0);
        check_value({tag, " busy_count"}, 64'(busys), 64'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] saved;

        Reset_n = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0; Flush = 1'b0;
        #1;
        check_value("reset busy", 64'(Busy), 64'd0);
        check_value("reset done", 64'(Done), 64'd0);
        check_value("reset hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Listed vectors.
        run_mul(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_value("multu max const", {Hi, Lo}, 64'hFFFFFFFE_00000001);
        run_mul(3'd0, 32'hFFFFFFFD, 32'd7);
        check_value("mult -3*7 const", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_single(3'd4, 32'h12345678, 32'd0);
        run_single(3'd5, 32'hFFFFFFFF, 32'd0);
        run_mul(3'd2, 32'd2, 32'd3);
        check_value("madd const", {Hi, Lo}, 64'h12345679_00000005);
        run_single(3'd4, 32'd0, 32'd0);
        run_single(3'd5, 32'd0, 32'd0);
        run_mul(3'd3, 32'd1, 32'd1);
        check_value("msub const", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);
        run_mul(3'd0, 32'h80000000, 32'h80000000);
        run_mul(3'd3, 32'h80000000, 32'hFFFFFFFF);

        // Flush in IDLE blocks a simultaneous Start.
        @(negedge Clk);
        Start = 1'b1; Op = 3'd4; A = 32'hCAFEF00D; Flush = 1'b1;
        @(negedge Clk);
        Op = 3'd0;
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        check_value("flush idle busy", 64'(Busy), 64'd0);
        check_value("flush idle hilo", {Hi, Lo}, model_hilo);

        // Start ignored while busy, then flush mid-operation.
        saved = model_hilo;
        @(negedge Clk);
        Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd6;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Start = 1'b1; Op = 3'd4; A = 32'hDEADBEEF;
        @(negedge Clk);
        Start = 1'b0;
        check_value("ignored mthi busy", 64'(Busy), 64'd1);
        repeat (4) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check_value("flush mul busy", 64'(Busy), 64'd0);
        check_value("flush mul hilo", {Hi, Lo}, saved);
        watch_quiet("after flush", 40);
        check_value("after flush hilo", {Hi, Lo}, saved);

        // Asynchronous reset in the middle of a MULTU.
        @(negedge Clk);
        Start = 1'b1; Op = 3'd1; A = 32'h00012345; B = 32'h00067890;
        @(negedge Clk);
        Start = 1'b0;
        repeat (19) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        model_hilo = '0;
        check_value("async reset busy", 64'(Busy), 64'd0);
        check_value("async reset done", 64'(Done), 64'd0);
        check_value("async reset hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        Start = 1'b1; Op = 3'd4; A = 32'h0BADF00D;
        @(negedge Clk);
        Start = 1'b0;
        model_hilo = {32'h0BADF00D, 32'd0};
        check_value("first edge mthi", {Hi, Lo}, model_hilo);
        watch_quiet("after reset", 40);

        // Randomized ops, operands biased toward sign/extreme values.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'hFFFFFFFF;
                1: b = 32'h80000000;
                2: begin a = 32'($urandom_range(0, 15)); b = -32'($urandom_range(0, 15)); end
                default: ;
            endcase
            if (op <= 3'd3) run_mul(op, a, b);
            else            run_single(op, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width and width of each of the HI and LO registers.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Start, input, 1 bit: request to issue Op this cycle.
REQ-005 SHALL have port Op, input, 3 bits: 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO; 110 and 111 are ignored.
REQ-006 SHALL have port A, input, WIDTH bits: rs operand.
REQ-007 SHALL have port B, input, WIDTH bits: rt operand.
REQ-008 SHALL have port Flush, input, 1 bit: abort any in-flight operation.
REQ-009 SHALL have port Busy, output, 1 bit: a multi-cycle operation is in flight; the hazard unit stalls on it.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle pulse when a multi-cycle result commits.
REQ-011 SHALL have port Hi, output, WIDTH bits: architectural HI register.
REQ-012 SHALL have port Lo, output, WIDTH bits: architectural LO register.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, MUL and FIX; Busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 In IDLE, Start=1 with Op in {000..011} and Flush=0 SHALL, at that edge, latch A, B and Op, clear the 64-bit partial product, set the step counter to 0 and enter MUL.
REQ-015 For signed ops (MULT, MADD, MSUB), the block SHALL latch |A| and |B| and record neg = A[WIDTH-1] XOR B[WIDTH-1]; MULTU SHALL use A and B unmodified.
REQ-016 MUL SHALL perform one shift-add step per cycle over 32 cycles (counter 0..31), then enter FIX.
REQ-017 FIX SHALL take one cycle and SHALL negate the product if neg=1.
REQ-018 At the FIX edge, MULT/MULTU SHALL write {Hi,Lo}=product, MADD SHALL write {Hi,Lo}={Hi,Lo}+product, and MSUB SHALL write {Hi,Lo}={Hi,Lo}-product.
REQ-019 All FIX arithmetic SHALL be modulo 2^64, with carry and borrow discarded.
REQ-020 At the FIX edge the block SHALL return to IDLE and assert Done for exactly the following cycle.
REQ-021 Latency SHALL be fixed: accept at edge 0, commit at edge 33, Busy high for 33 cycles, Done high in the cycle after edge 33.
REQ-022 In IDLE, Start=1 with Op=100 SHALL write Hi=A at that edge; with Op=101 it SHALL write Lo=A at that edge.
REQ-023 MTHI and MTLO SHALL be single-cycle, SHALL NOT raise Busy and SHALL NOT pulse Done.
REQ-024 Start while Busy=1 SHALL be ignored entirely: no latch, no Hi/Lo write, no restart.
REQ-025 Start with Op=110 or 111 SHALL have no effect.
REQ-026 Flush=1 in MUL or FIX SHALL return the FSM to IDLE at that edge, leave Hi/Lo unchanged and suppress Done.
REQ-027 Flush=1 in IDLE SHALL block a simultaneous Start, including MTHI/MTLO.
REQ-028 Hi and Lo SHALL change only at the FIX commit edge, at an accepted MTHI/MTLO edge, or on reset.

Reset
REQ-029 Reset_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, Busy=0, Done=0, Hi=0, Lo=0, step counter=0 and partial product=0.
REQ-030 Reset asserted mid-operation SHALL discard the operation; after release no Done SHALL be emitted for it.
REQ-031 The first rising edge after Reset_n rises SHALL accept a Start normally.

Verification
REQ-032 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles, then Hi=0xFFFFFFFE, Lo=0x00000001, Done high for exactly 1 cycle.
REQ-033 MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
REQ-034 MTHI A=0x12345678, then MTLO A=0xFFFFFFFF, then MADD A=2, B=3 -> Hi=0x12345679, Lo=0x00000005; no Busy during the MTHI/MTLO cycles.
REQ-035 Hi=Lo=0, then MSUB A=1, B=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
REQ-036 MULT in flight: Start MTHI at cycle 5 -> ignored; Flush at cycle 10 -> Busy low next cycle, Hi/Lo unchanged, no Done.
REQ-037 Reset_n pulsed low at cycle 20 of a MULTU -> Busy, Done, Hi and Lo are 0 immediately, and no Done follows release.
